// File: rtl/phase_ctrl_pkg.sv
// phase_ctrl_pkg
// Shared definitions for the phase-bus consumer: phase bit positions, bus
// width, controller state encoding and small helpers for phase arithmetic.
package phase_ctrl_pkg;

    localparam int PH_W = 5;

    localparam int PH_F_BIT = 0;
    localparam int PH_R_BIT = 1;
    localparam int PH_X_BIT = 2;
    localparam int PH_M_BIT = 3;
    localparam int PH_W_BIT = 4;

    localparam logic [PH_W-1:0] PH_NONE = '0;
    localparam logic [PH_W-1:0] PH_F    = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Phase that must follow ph on a healthy bus (ph_w wraps back to ph_f).
    function automatic logic [PH_W-1:0] ph_rotl(input logic [PH_W-1:0] ph);
        return {ph[PH_W-2:0], ph[PH_W-1]};
    endfunction

    function automatic logic is_onehot(input logic [PH_W-1:0] ph);
        return (ph != PH_NONE) &&
               ((ph & (ph - {{(PH_W-1){1'b0}}, 1'b1})) == PH_NONE);
    endfunction

endpackage

// File: rtl/phase_seq_chk.sv
// phase_seq_chk
// Decides whether the phase seen this cycle is acceptable given the
// controller state and the phase seen on the previous cycle.
// Ports:
//   phase   in   current one-hot phase (0 = sequencer stopped)
//   prev_ph in   phase registered on the previous cycle
//   state   in   controller state
//   legal   out  1 when the phase is allowed in this state
module phase_seq_chk
    import phase_ctrl_pkg::*;
(
    input  logic [PH_W-1:0] phase,
    input  logic [PH_W-1:0] prev_ph,
    input  state_t          state,
    output logic            legal
);

    always_comb begin
        legal = 1'b0;
        case (state)
            ST_IDLE:   legal = (phase == PH_NONE) || (phase == PH_F);
            // prev_ph is always a single legal phase while running, so the
            // rotation alone pins the answer; the one-hot term keeps the
            // multi-bit rejection explicit.
            ST_RUN:    legal = is_onehot(phase) && (phase == ph_rotl(prev_ph));
            ST_HALTED: legal = (phase == PH_NONE);
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_ctrl.sv
// phase_ctrl
// Consumer end of the 5-phase one-hot sequencer bus. Produces per-phase
// datapath strobes, requests a halt when a halt instruction reaches ph_w,
// flags protocol violations (sticky) and counts retired instructions.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   phase[4:0]          one-hot phase, bit0=ph_f .. bit4=ph_w, 0 = stopped
//   is_hlt/is_ld/is_st  decoded instruction class, valid from ph_r onward
//   wb_en               decoded instruction writes the register file
//   ir_we, rf_re, alu_we, mem_re, mem_we, pc_we, rf_we   datapath strobes
//   hlt                 halt request to the sequencer (ph_w only)
//   err                 sticky protocol-violation flag
//   retired[CNT_W-1:0]  retired-instruction count, wraps
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | bus stopped; waiting for ph_f to start an instruction
// ST_RUN    | instruction in flight; each phase must rotate from the last
// ST_HALTED | halt retired on the previous ph_w; bus must be stopped
// ST_ERR    | protocol violation seen; held until reset
module phase_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PH_W-1:0]  phase,
    input  logic             is_hlt,
    input  logic             is_ld,
    input  logic             is_st,
    input  logic             wb_en,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_re,
    output logic             alu_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             rf_we,
    output logic             hlt,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t          state;
    logic [PH_W-1:0] prev_ph;
    logic            halt_pend;
    logic            legal;
    logic            active;

    phase_seq_chk u_seq_chk (
        .phase   (phase),
        .prev_ph (prev_ph),
        .state   (state),
        .legal   (legal)
    );

    // Strobes may fire while running, and on the ph_f that starts an
    // instruction from idle, so the first fetch is not lost. Reset masks
    // them because idle + ph_f would otherwise pass straight through.
    assign active = !rst && legal &&
                    ((state == ST_RUN) || ((state == ST_IDLE) && (phase == PH_F)));

    assign ir_we  = active && phase[PH_F_BIT];
    assign rf_re  = active && phase[PH_R_BIT];
    assign alu_we = active && phase[PH_X_BIT];
    assign mem_re = active && phase[PH_M_BIT] && is_ld;
    assign mem_we = active && phase[PH_M_BIT] && is_st;
    assign pc_we  = active && phase[PH_W_BIT];
    assign rf_we  = active && phase[PH_W_BIT] && wb_en;

    // The sequencer samples hlt on the same edge that ends ph_w.
    assign hlt = !rst && (state == ST_RUN) && phase[PH_W_BIT] && halt_pend;

    assign err = (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prev_ph   <= PH_NONE;
            halt_pend <= 1'b0;
            retired   <= '0;
        end else begin
            prev_ph <= phase;

            // legal is never set in ST_ERR, so this also holds the error state.
            if (!legal) begin
                state <= ST_ERR;
            end else begin
                case (state)
                    ST_IDLE:   if (phase == PH_F) state <= ST_RUN;
                    ST_RUN:    if (hlt) state <= ST_HALTED;
                    ST_HALTED: state <= ST_IDLE;
                    default:   state <= ST_ERR;
                endcase
            end

            if (state == ST_HALTED) begin
                halt_pend <= 1'b0;
            end else if (active && phase[PH_R_BIT] && is_hlt) begin
                halt_pend <= 1'b1;
            end

            if (active && phase[PH_W_BIT]) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_phase_ctrl.sv
module tb_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] phase = 5'd0;
    logic       is_hlt = 1'b0, is_ld = 1'b0, is_st = 1'b0, wb_en = 1'b0;

    logic a_ir_we, a_pc_we, a_rf_re, a_alu_we, a_mem_re, a_mem_we, a_rf_we, a_hlt, a_err;
    logic b_ir_we, b_pc_we, b_rf_re, b_alu_we, b_mem_re, b_mem_we, b_rf_we, b_hlt, b_err;
    logic [15:0] a_retired;
    logic [3:0]  b_retired;

    always #5 clk = ~clk;

    phase_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .phase(phase), .is_hlt(is_hlt), .is_ld(is_ld),
        .is_st(is_st), .wb_en(wb_en), .ir_we(a_ir_we), .pc_we(a_pc_we),
        .rf_re(a_rf_re), .alu_we(a_alu_we), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .rf_we(a_rf_we), .hlt(a_hlt), .err(a_err), .retired(a_retired)
    );

    phase_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .phase(phase), .is_hlt(is_hlt), .is_ld(is_ld),
        .is_st(is_st), .wb_en(wb_en), .ir_we(b_ir_we), .pc_we(b_pc_we),
        .rf_re(b_rf_re), .alu_we(b_alu_we), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .rf_we(b_rf_we), .hlt(b_hlt), .err(b_err), .retired(b_retired)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: instruction-level view of the bus.
    bit          m_run, m_halted, m_broken, m_pend;
    int          m_nxt;      // index of the phase expected next while running
    int unsigned m_count;    // instructions retired since reset

    // strobe vector layout: {ir_we, rf_re, alu_we, mem_re, mem_we, pc_we, rf_we, hlt}
    function automatic logic [7:0] a_vec();
        return {a_ir_we, a_rf_re, a_alu_we, a_mem_re, a_mem_we, a_pc_we, a_rf_we, a_hlt};
    endfunction

    function automatic logic [7:0] b_vec();
        return {b_ir_we, b_rf_re, b_alu_we, b_mem_re, b_mem_we, b_pc_we, b_rf_we, b_hlt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_halted = 0; m_broken = 0; m_pend = 0; m_nxt = 0; m_count = 0;
    endtask

    function automatic void model_expect(output logic [7:0] sv, output bit lg);
        bit ok, act;
        int ones;
        ones = $countones(phase);
        if (m_broken)      ok = 0;
        else if (m_halted) ok = (phase == 5'd0);
        else if (m_run)    ok = (ones == 1) && (phase == 5'(1 << m_nxt));
        else               ok = (phase == 5'd0) || (phase == 5'd1);
        act = !rst && ok && !m_broken && !m_halted && (m_run || phase == 5'd1);
        sv[7] = act && phase[0];
        sv[6] = act && phase[1];
        sv[5] = act && phase[2];
        sv[4] = act && phase[3] && is_ld;
        sv[3] = act && phase[3] && is_st;
        sv[2] = act && phase[4];
        sv[1] = act && phase[4] && wb_en;
        sv[0] = !rst && m_run && phase[4] && m_pend;
        lg = ok;
    endfunction

    task automatic model_update(input bit lg);
        if (rst || m_broken) return;
        if (!lg) begin
            m_broken = 1; m_run = 0; m_halted = 0;
        end else if (m_halted) begin
            m_halted = 0; m_pend = 0;
        end else if (m_run) begin
            if (phase[1] && is_hlt) m_pend = 1;
            if (phase[4]) begin
                m_count++;
                if (m_pend) begin m_run = 0; m_halted = 1; end
            end
            m_nxt = (m_nxt + 1) % 5;
        end else if (phase == 5'd1) begin
            m_run = 1; m_nxt = 1;
        end
    endtask

    task automatic model_cmp();
        logic [7:0] sv;
        bit lg;
        model_expect(sv, lg);
        check("strobes", 32'(a_vec()), 32'(sv));
        check("strobes_w4", 32'(b_vec()), 32'(sv));
        check("err", 32'(a_err), 32'(m_broken));
        check("err_w4", 32'(b_err), 32'(m_broken));
        check("retired", 32'(a_retired), m_count & 32'hffff);
        check("retired_w4", 32'(b_retired), m_count & 32'hf);
        model_update(lg);
    endtask

    // One bus cycle: drive just after posedge, compare at negedge.
    task automatic step(input bit r, input logic [4:0] p, input bit h, input bit l,
                        input bit s, input bit w);
        @(posedge clk);
        #1;
        rst = r; phase = p; is_hlt = h; is_ld = l; is_st = s; wb_en = w;
        if (r) model_reset();
        @(negedge clk);
        model_cmp();
    endtask

    typedef struct {
        bit         r;
        logic [4:0] p;
        bit         h, l, s, w;
        logic [7:0] sv;
        bit         e;
        int         ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [4:0] p, bit h, bit l, bit s, bit w,
                                logic [7:0] sv, bit e, int ret);
        vec_t v;
        v.r = r; v.p = p; v.h = h; v.l = l; v.s = s; v.w = w;
        v.sv = sv; v.e = e; v.ret = ret;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        //              r  phase  h  l  s  w  strobes e ret
        tbl.push_back(mk(1, 5'd0,  0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 5'd1,  0, 0, 0, 0, 8'h80, 0, 0));
        tbl.push_back(mk(0, 5'd2,  0, 0, 0, 0, 8'h40, 0, 0));
        tbl.push_back(mk(0, 5'd4,  0, 0, 0, 0, 8'h20, 0, 0));
        tbl.push_back(mk(0, 5'd8,  0, 1, 0, 0, 8'h10, 0, 0));
        tbl.push_back(mk(0, 5'd16, 0, 0, 0, 1, 8'h06, 0, 0));
        tbl.push_back(mk(0, 5'd1,  0, 0, 0, 0, 8'h80, 0, 1));
        tbl.push_back(mk(0, 5'd2,  1, 0, 0, 0, 8'h40, 0, 1));
        tbl.push_back(mk(0, 5'd4,  1, 0, 0, 0, 8'h20, 0, 1));
        tbl.push_back(mk(0, 5'd8,  1, 0, 1, 0, 8'h08, 0, 1));
        tbl.push_back(mk(0, 5'd16, 1, 0, 0, 1, 8'h07, 0, 1));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(0, 5'd1,  0, 0, 0, 0, 8'h80, 0, 2));
        tbl.push_back(mk(0, 5'd2,  0, 0, 0, 0, 8'h40, 0, 2));
        tbl.push_back(mk(0, 5'd8,  0, 1, 0, 1, 8'h00, 0, 2));
        tbl.push_back(mk(0, 5'd16, 0, 0, 0, 1, 8'h00, 1, 2));
        tbl.push_back(mk(0, 5'd1,  0, 0, 0, 0, 8'h00, 1, 2));
        tbl.push_back(mk(1, 5'd0,  0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 5'd3,  0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 5'd1,  0, 0, 0, 0, 8'h00, 1, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].p, tbl[i].h, tbl[i].l, tbl[i].s, tbl[i].w);
            check($sformatf("tbl%0d_strobes", i), 32'(a_vec()), 32'(tbl[i].sv));
            check($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].e));
            check($sformatf("tbl%0d_retired", i), 32'(a_retired), 32'(tbl[i].ret));
        end

        // Reset during ph_x, then a clean restart and a bad restart.
        step(1, 5'd0, 0, 0, 0, 0);
        step(0, 5'd0, 0, 0, 0, 0);
        foreach (tbl[i]) if (i >= 2 && i <= 6) step(0, tbl[i].p, 0, 1, 1, 1);
        step(0, 5'd1, 0, 0, 0, 0);
        step(0, 5'd2, 0, 0, 0, 0);
        step(0, 5'd4, 0, 0, 0, 0);
        check("pre_rst_alu_we", 32'(a_alu_we), 32'd1);
        check("pre_rst_retired", 32'(a_retired), 32'd1);
        step(1, 5'd4, 0, 0, 0, 0);
        check("rst_mid_x_strobes", 32'(a_vec()), 32'd0);
        check("rst_mid_x_retired", 32'(a_retired), 32'd0);
        check("rst_mid_x_err", 32'(a_err), 32'd0);
        step(0, 5'd1, 0, 0, 0, 0);
        check("restart_ir_we", 32'(a_vec()), 32'h80);
        step(0, 5'd2, 0, 0, 0, 0);
        step(1, 5'd4, 0, 0, 0, 0);
        step(0, 5'd16, 0, 0, 0, 1);
        check("bad_restart_strobes", 32'(a_vec()), 32'd0);
        step(0, 5'd0, 0, 0, 0, 0);
        check("bad_restart_err", 32'(a_err), 32'd1);

        // Narrow counter wraps after 16 instructions.
        step(1, 5'd0, 0, 0, 0, 0);
        step(0, 5'd0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 5; b++) begin
                step(0, 5'(1 << b), 0, 0, 0, $urandom_range(0, 1) == 1);
                if (k == 15 && b == 0) check("wrap_at_15", 32'(b_retired), 32'd15);
            end
        end
        step(0, 5'd1, 0, 0, 0, 0);
        check("wrap_to_0", 32'(b_retired), 32'd0);
        check("wide_16", 32'(a_retired), 32'd16);
        check("wrap_no_err", 32'(b_err), 32'd0);

        // Randomised traffic: mostly well-formed, occasional glitches and resets.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            logic [4:0] p;
            r = m_broken ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) p = 5'($urandom_range(0, 31));
            else if (m_halted)              p = 5'd0;
            else if (m_run)                 p = 5'(1 << m_nxt);
            else                            p = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'd1;
            step(r, p, $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
